// File: rtl/fb_rect_renderer_pkg.sv
// rtl/fb_rect_renderer_pkg.sv - shared framebuffer geometry, colour codes and op encodings
package fb_rect_renderer_pkg;

    localparam int PX_WIDTH  = 160;
    localparam int PX_HEIGHT = 120;
    localparam int ADDR_W    = 16;
    localparam int CODE_W    = 3;

    localparam logic [CODE_W-1:0] CODE_BG        = 3'd0;
    localparam logic [CODE_W-1:0] CODE_ORANGE    = 3'd1;
    localparam logic [CODE_W-1:0] CODE_STEELGREY = 3'd2;
    localparam logic [CODE_W-1:0] CODE_YELLOW    = 3'd3;
    localparam logic [CODE_W-1:0] CODE_CRIMSON   = 3'd4;
    localparam logic [CODE_W-1:0] CODE_PLAYER    = 3'd6;

    localparam logic OP_FILL  = 1'b0;
    localparam logic OP_CLEAR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLIP = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/fb_rect_renderer.sv
// rtl/fb_rect_renderer.sv - rectangle fill / clear rasteriser into the framebuffer write port
// Optional FBR_VSYNC_GATE_EN: limits clear commands to one per frame.
module fb_rect_renderer #(
    parameter int         PX_WIDTH  = fb_rect_renderer_pkg::PX_WIDTH,
    parameter int         PX_HEIGHT = fb_rect_renderer_pkg::PX_HEIGHT,
    parameter logic [2:0] BG_CODE   = fb_rect_renderer_pkg::CODE_BG
) (
    input  logic        dclk,
    input  logic        clr,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [7:0]  cmd_x0,
    input  logic [6:0]  cmd_y0,
    input  logic [7:0]  cmd_x1,
    input  logic [6:0]  cmd_y1,
    input  logic [2:0]  cmd_code,
    input  logic        frame_tick,
    output logic        wmem_we,
    output logic [15:0] wmemaddr,
    output logic [2:0]  wmemdata,
    output logic        busy,
    output logic        done
);
    import fb_rect_renderer_pkg::*;

    localparam logic [7:0]  XMAX     = 8'(PX_WIDTH - 1);
    localparam logic [6:0]  YMAX     = 7'(PX_HEIGHT - 1);
    localparam logic [15:0] ROW_STEP = 16'(PX_WIDTH);

    state_t      state;
    logic        rdy_q;
    logic        accept;
    logic        op_q;
    logic [7:0]  x0_q, x1_q;
    logic [6:0]  y0_q, y1_q;
    logic [2:0]  code_q;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [15:0] row_base;

    logic [7:0]  rx0, rx1;
    logic [6:0]  ry0, ry1;
    logic [2:0]  rcode;
    logic        empty;
    logic [15:0] base0;

`ifdef FBR_VSYNC_GATE_EN
    logic armed;

    // Set wins over the clear-accept so a tick coinciding with a clear re-arms.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            armed <= 1'b1;
        end else if (frame_tick) begin
            armed <= 1'b1;
        end else if (accept && cmd_op == OP_CLEAR) begin
            armed <= 1'b0;
        end
    end

    assign cmd_ready = rdy_q && !(cmd_op == OP_CLEAR && !armed);
`else
    logic unused_tick;
    assign unused_tick = frame_tick;
    assign cmd_ready   = rdy_q;
`endif

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        rx0   = x0_q;
        ry0   = y0_q;
        rx1   = (x1_q > XMAX) ? XMAX : x1_q;
        ry1   = (y1_q > YMAX) ? YMAX : y1_q;
        rcode = code_q;
        if (op_q == OP_CLEAR) begin
            rx0   = 8'd0;
            ry0   = 7'd0;
            rx1   = XMAX;
            ry1   = YMAX;
            rcode = BG_CODE;
        end
    end

    assign empty = (rx0 > rx1) || (ry0 > ry1) || (rx0 > XMAX) || (ry0 > YMAX);
    // The only multiply: row base of the first row, evaluated once in CLIP.
    assign base0 = 16'(ry0) * ROW_STEP;

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            rdy_q    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            wmem_we  <= 1'b0;
            wmemaddr <= 16'd0;
            wmemdata <= 3'd0;
            op_q     <= OP_FILL;
            x0_q     <= 8'd0;
            x1_q     <= 8'd0;
            y0_q     <= 7'd0;
            y1_q     <= 7'd0;
            code_q   <= 3'd0;
            x        <= 8'd0;
            y        <= 7'd0;
            row_base <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        op_q   <= cmd_op;
                        x0_q   <= cmd_x0;
                        y0_q   <= cmd_y0;
                        x1_q   <= cmd_x1;
                        y1_q   <= cmd_y1;
                        code_q <= cmd_code;
                        rdy_q  <= 1'b0;
                        busy   <= 1'b1;
                        state  <= CLIP;
                    end
                end
                CLIP: begin
                    x0_q     <= rx0;
                    y0_q     <= ry0;
                    x1_q     <= rx1;
                    y1_q     <= ry1;
                    code_q   <= rcode;
                    x        <= rx0;
                    y        <= ry0;
                    row_base <= base0;
                    if (empty) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        wmem_we  <= 1'b1;
                        wmemaddr <= base0 + 16'(rx0);
                        wmemdata <= rcode;
                        state    <= DRAW;
                    end
                end
                DRAW: begin
                    if (x == x1_q && y == y1_q) begin
                        wmem_we <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else if (x == x1_q) begin
                        x        <= x0_q;
                        y        <= y + 7'd1;
                        row_base <= row_base + ROW_STEP;
                        wmemaddr <= row_base + ROW_STEP + 16'(x0_q);
                    end else begin
                        x        <= x + 8'd1;
                        wmemaddr <= row_base + 16'(x) + 16'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    rdy_q <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_renderer.sv
// tb/tb_fb_rect_renderer.sv - self-checking bench for fb_rect_renderer (FBR_VSYNC_GATE_EN section optional)
module tb_fb_rect_renderer;

    localparam int PXW = 160;
    localparam int PXH = 120;

    logic        dclk = 1'b0;
    logic        clr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [7:0]  cmd_x0, cmd_x1;
    logic [6:0]  cmd_y0, cmd_y1;
    logic [2:0]  cmd_code;
    logic        frame_tick;
    logic        wmem_we;
    logic [15:0] wmemaddr;
    logic [2:0]  wmemdata;
    logic        busy;
    logic        done;

    fb_rect_renderer dut (
        .dclk(dclk), .clr(clr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_code(cmd_code), .frame_tick(frame_tick),
        .wmem_we(wmem_we), .wmemaddr(wmemaddr), .wmemdata(wmemdata),
        .busy(busy), .done(done)
    );

    always #5 dclk = ~dclk;

    typedef struct {
        logic       op;
        logic [7:0] x0;
        logic [6:0] y0;
        logic [7:0] x1;
        logic [6:0] y1;
        logic [2:0] code;
        int         exp_n;
        int         exp_last;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [18:0] sb[$];
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_model(input vec_t v);
        int ax0, ay0, ax1, ay1;
        logic [2:0] c;
        if (v.op) begin
            ax0 = 0; ay0 = 0; ax1 = PXW - 1; ay1 = PXH - 1; c = 3'd0;
        end else begin
            ax0 = v.x0; ay0 = v.y0;
            ax1 = (v.x1 > PXW - 1) ? PXW - 1 : int'(v.x1);
            ay1 = (v.y1 > PXH - 1) ? PXH - 1 : int'(v.y1);
            c = v.code;
        end
        for (int yy = ay0; yy <= ay1; yy++)
            for (int xx = ax0; xx <= ax1; xx++)
                sb.push_back({16'(yy * PXW + xx), c});
    endtask

    task automatic drive(input vec_t v);
        cmd_op = v.op; cmd_x0 = v.x0; cmd_y0 = v.y0;
        cmd_x1 = v.x1; cmd_y1 = v.y1; cmd_code = v.code;
    endtask

    task automatic pop_write(input int cyc);
        logic [18:0] e;
        if (sb.size() == 0) begin
            chk("unexpected_write", {16'd0, wmemaddr}, 32'hffff_ffff);
        end else begin
            e = sb.pop_front();
            chk($sformatf("waddr@%0d", cyc), {16'd0, wmemaddr}, {16'd0, e[18:3]});
            chk($sformatf("wdata@%0d", cyc), {29'd0, wmemdata}, {29'd0, e[2:0]});
        end
    endtask

    // tick_at: cycle after accept at which a frame_tick pulse is injected (-1 = none)
    task automatic run_cmd(input vec_t v, input int tick_at, input string tag);
        int cyc, nw, first_w, last_w, dc, to;
        logic [15:0] last_a;
        cyc = 0; nw = 0; first_w = -1; last_w = -1; dc = -1; to = 0; last_a = 16'd0;
        push_model(v);
        drive(v);
        cmd_valid = 1'b1;
        while (!cmd_ready && to < 100) begin
            @(negedge dclk);
            to++;
        end
        chk({tag, "_ready_at_accept"}, {31'd0, cmd_ready}, 32'd1);
        @(posedge dclk);
        #1 cmd_valid = 1'b0;
        while (dc < 0 && cyc < 20100) begin
            @(negedge dclk);
            cyc++;
            frame_tick = (cyc == tick_at);
            if (cyc == 1) begin
                chk({tag, "_clip_ready"}, {31'd0, cmd_ready}, 32'd0);
                chk({tag, "_clip_we"}, {31'd0, wmem_we}, 32'd0);
            end
            if (busy !== 1'b1) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (wmem_we) begin
                pop_write(cyc);
                nw++;
                if (first_w < 0) first_w = cyc;
                last_w = cyc;
                last_a = wmemaddr;
            end
            if (done) dc = cyc;
        end
        frame_tick = 1'b0;
        chk({tag, "_done_cycle"}, dc, 2 + v.exp_n);
        chk({tag, "_nwrites"}, nw, v.exp_n);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        if (v.exp_n > 0) begin
            chk({tag, "_first_w"}, first_w, 2);
            chk({tag, "_last_w"}, last_w, 1 + v.exp_n);
            chk({tag, "_last_addr"}, {16'd0, last_a}, v.exp_last);
        end
        sb.delete();
        @(negedge dclk);
        chk({tag, "_ready_after"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_after"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        vec_t clrv;
        clr = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_x0 = 8'd0; cmd_y0 = 7'd0;
        cmd_x1 = 8'd0; cmd_y1 = 7'd0; cmd_code = 3'd0; frame_tick = 1'b0;

        //             op    x0     y0     x1     y1     code  n      last
        vecs[0] = '{1'b0, 8'd2,   7'd3,   8'd4,   7'd4,   3'd3, 6,     644};
        vecs[1] = '{1'b1, 8'd9,   7'd9,   8'd1,   7'd1,   3'd5, 19200, 19199};
        vecs[2] = '{1'b0, 8'd150, 7'd115, 8'd200, 7'd127, 3'd4, 50,    19199};
        vecs[3] = '{1'b0, 8'd10,  7'd0,   8'd5,   7'd0,   3'd1, 0,     0};
        vecs[4] = '{1'b0, 8'd170, 7'd0,   8'd180, 7'd5,   3'd1, 0,     0};
        vecs[5] = '{1'b0, 8'd159, 7'd119, 8'd159, 7'd119, 3'd6, 1,     19199};
        vecs[6] = '{1'b0, 8'd0,   7'd0,   8'd159, 7'd0,   3'd2, 160,   159};
        vecs[7] = '{1'b0, 8'd0,   7'd10,  8'd5,   7'd5,   3'd2, 0,     0};
        vecs[8] = '{1'b0, 8'd0,   7'd120, 8'd3,   7'd127, 3'd2, 0,     0};

        repeat (2) @(negedge dclk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_we", {31'd0, wmem_we}, 32'd0);
        chk("rst_addr", {16'd0, wmemaddr}, 32'd0);
        chk("rst_data", {29'd0, wmemdata}, 32'd0);
        clr = 1'b0;
        @(negedge dclk);

        for (int i = 0; i < 9; i++) run_cmd(vecs[i], -1, $sformatf("vec%0d", i));

        run_cmd(vecs[0], 4, "tick_mid");

        // Reset in the middle of a clear: outputs drop within the same cycle.
        clrv = vecs[1];
        drive(clrv);
        cmd_valid = 1'b1;
        @(posedge dclk);
        #1 cmd_valid = 1'b0;
        push_model(clrv);
        for (int c = 1; c <= 12; c++) begin
            @(negedge dclk);
            if (wmem_we) pop_write(c);
        end
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        @(posedge dclk);
        #2 clr = 1'b1;
        #1;
        chk("arst_we", {31'd0, wmem_we}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("arst_addr", {16'd0, wmemaddr}, 32'd0);
        sb.delete();
        @(negedge dclk);
        clr = 1'b0;
        @(negedge dclk);
        run_cmd(vecs[0], -1, "post_rst");

`ifdef FBR_VSYNC_GATE_EN
        run_cmd(vecs[1], -1, "gate_clear1");
        drive(vecs[1]);
        cmd_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge dclk);
            if (cmd_ready) n++;
        end
        chk("gate_clear_stalled", n, 0);
        cmd_op = 1'b0;
        #1 chk("gate_fill_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b0;
        run_cmd(vecs[0], -1, "gate_fill");
        drive(vecs[1]);
        cmd_valid = 1'b1;
        #1 chk("gate_still_stalled", {31'd0, cmd_ready}, 32'd0);
        frame_tick = 1'b1;
        @(negedge dclk);
        frame_tick = 1'b0;
        chk("gate_rearmed", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b0;
`else
        n = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
